// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-FF synchronised input, 3-sample majority vote at mid-bit,
// configurable data width / parity / stop bits, frame delivered on a valid/ready port.
//
// state | meaning
// IDLE  | line idle, waiting for a synced 1->0 edge
// START | start bit; a high vote rejects the edge as a glitch
// DATA  | shifting data bits in, LSB first
// PAR   | capturing the parity bit
// STOP  | checking stop bits; leaves at the decision point of the last one
module uart_rx_ovs #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_SA   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_SB   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_nx;
    logic                   rx_s1, rx_s2, rx_prev, fall_q;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic                   stop_idx;
    logic                   samp_a, samp_b;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   stop_bad;
    logic                   vote, at_dec, at_end, done;
    logic                   par_x, perr_nx, ferr_nx;

    assign vote    = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    assign at_dec  = (cnt == CNT_DEC);
    assign at_end  = (cnt == CNT_LAST);
    assign par_x   = (^shreg) ^ par_bit;
    assign perr_nx = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;
    // The last stop bit's vote is not registered yet when the frame completes.
    assign ferr_nx = stop_bad | ~vote;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:  if (fall_q) state_nx = START;
            START: begin
                if (at_dec && vote) state_nx = IDLE;
                else if (at_end)    state_nx = DATA;
            end
            DATA:  if (at_end && bit_idx == BIT_LAST) state_nx = (PARITY != 0) ? PAR : STOP;
            PAR:   if (at_end) state_nx = STOP;
            STOP:  begin
                if (at_dec && stop_idx == STOP_LAST) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            fall_q   <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            fall_q  <= rx_prev & ~rx_s2;
            // cnt holds 0 through IDLE so the first START cycle sees 0.
            if (state == IDLE || state_nx == IDLE) cnt <= '0;
            else if (at_end)                       cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
            if (cnt == CNT_SA) samp_a <= rx_s2;
            if (cnt == CNT_SB) samp_b <= rx_s2;
            if (state == IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (state == DATA && at_dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (state == DATA && at_end) bit_idx <= bit_idx + 1'b1;
            if (state == PAR && at_dec) par_bit <= vote;
            if (state == STOP && at_dec) stop_bad <= stop_bad | ~vote;
            if (state == STOP && at_end) stop_idx <= stop_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr_nx;
                    frame_err  <= ferr_nx;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: three instances (8N1, 7E1, 8N2) driven by a serial frame task;
// frames are predicted into a queue and matched against handshakes seen on each port.
module tb_uart_rx_ovs;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } frm_t;

    logic       clk, rst;
    logic       rx_a, rx_b, rx_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] da, dc;
    logic [6:0] db;
    logic       va, vb, vc, pa, pb_o, pc, fa, fb, fc, ova, ovb, ovc, bsa, bsb, bsc;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ov_cnt = 0;
    int   ov_cyc = 0;
    int   last_fall = 0;
    int   last_got_cyc = 0;
    frm_t exp_q[$];
    frm_t got_q[$];

    uart_rx_ovs #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(da), .rx_valid(va), .rx_ready(rdy_a),
        .parity_err(pa), .frame_err(fa), .overrun(ova), .busy(bsa));
    uart_rx_ovs #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(db), .rx_valid(vb), .rx_ready(rdy_b),
        .parity_err(pb_o), .frame_err(fb), .overrun(ovb), .busy(bsb));
    uart_rx_ovs #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx(rx_c), .rx_data(dc), .rx_valid(vc), .rx_ready(rdy_c),
        .parity_err(pc), .frame_err(fc), .overrun(ovc), .busy(bsc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (va && rdy_a) got_q.push_back('{0, 9'(da), pa, fa, cyc});
            if (vb && rdy_b) got_q.push_back('{1, 9'(db), pb_o, fb, cyc});
            if (vc && rdy_c) got_q.push_back('{2, 9'(dc), pc, fc, cyc});
            if (ova) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drives one frame; spike inverts one cycle at mid-bit of frame bit 'spike';
    // lim truncates the frame to its first lim bits (line left at the last bit).
    task automatic send(input int sel, input logic [8:0] d, input int nd, input int pe,
                        input logic pbit, input logic [1:0] st, input int ns,
                        input int spike, input int lim, input bit push);
        logic [15:0] f;
        logic [8:0]  dm;
        logic        x;
        int          n;
        frm_t        e;
        f  = '0;
        dm = '0;
        x  = 1'b0;
        n  = 1;
        for (int i = 0; i < nd; i++) begin
            f[n]  = d[i];
            dm[i] = d[i];
            x     = x ^ d[i];
            n++;
        end
        if (pe != 0) begin
            f[n] = pbit;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            f[n] = st[i];
            n++;
        end
        if (push) begin
            e.sel  = sel;
            e.data = dm;
            e.perr = (pe != 0) ? (x ^ pbit) : 1'b0;
            e.ferr = (ns == 2) ? ~(st[0] & st[1]) : ~st[0];
            e.cyc  = 0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        last_fall = cyc;
        for (int b = 0; b < n && b < lim; b++) begin
            set_rx(sel, f[b]);
            if (b == spike) begin
                repeat (9) @(posedge clk);
                #1 set_rx(sel, ~f[b]);
                @(posedge clk);
                #1 set_rx(sel, f[b]);
                repeat (6) @(posedge clk);
            end else begin
                repeat (16) @(posedge clk);
            end
            #1;
        end
        if (lim >= n) begin
            set_rx(sel, 1'b1);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag);
        frm_t g, e;
        for (int i = 0; i < 400 && got_q.size() == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_handshakes"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_port"}, 32'(g.sel), 32'(e.sel));
            chk({tag, "_data"}, 32'(g.data), 32'(e.data));
            chk({tag, "_parity_err"}, 32'(g.perr), 32'(e.perr));
            chk({tag, "_frame_err"}, 32'(g.ferr), 32'(e.ferr));
            last_got_cyc = g.cyc;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   t0, ov0, lat;
        frm_t e;
        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_a", 32'({va, da, pa, fa, ova, bsa}), 32'd0);
        chk("reset_busy_bc", 32'({bsb, vb, bsc, vc}), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Baseline 8N1 with latency measured from the first edge that sees the pin low.
        send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, -1, 99, 1);
        t0 = last_fall;
        check_frame("base_a5");
        lat = last_got_cyc - t0 - 1;
        chk("base_latency", 32'(lat), 32'd157);

        send(0, 9'h000, 8, 0, 1'b0, 2'b11, 1, 3, 99, 1);
        check_frame("spike_00");

        send(0, 9'h06E, 8, 0, 1'b0, 2'b11, 1, -1, 99, 1);
        check_frame("data_6e");

        // Short low pulse must be rejected in START.
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_busy_mid", 32'(bsa), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_end", 32'(bsa), 32'd0);
        chk("glitch_no_frame", 32'(got_q.size()), 32'd0);

        // Backpressure: second frame dropped with a single overrun pulse.
        rdy_a = 1'b0;
        ov0 = ov_cnt;
        send(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, -1, 99, 1);
        send(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1, -1, 99, 0);
        t0 = last_fall;
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_count", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_latency", 32'(ov_cyc - t0 - 1), 32'd157);
        chk("ovr_valid_held", 32'(va), 32'd1);
        chk("ovr_data_kept", 32'(da), 32'h3C);
        rdy_a = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_drop", 32'(va), 32'd0);
        check_frame("ovr_3c");

        // 7E1 parity good and bad.
        send(1, 9'h055, 7, 1, 1'b0, 2'b11, 1, -1, 99, 1);
        check_frame("par_ok");
        send(1, 9'h055, 7, 1, 1'b1, 2'b11, 1, -1, 99, 1);
        check_frame("par_bad");

        // 8N2: second stop bit low.
        send(2, 9'h05A, 8, 0, 1'b0, 2'b01, 2, -1, 99, 1);
        check_frame("stop2_low");

        // Break: exactly one all-zero frame with a framing error.
        @(posedge clk);
        #1 rx_c = 1'b0;
        e = '{2, 9'h000, 1'b0, 1'b1, 0};
        exp_q.push_back(e);
        repeat (640) @(posedge clk);
        #1 rx_c = 1'b1;
        repeat (40) @(posedge clk);
        check_frame("break");
        send(2, 9'h096, 8, 0, 1'b0, 2'b11, 2, -1, 99, 1);
        check_frame("after_break");

        // Reset mid-frame, then a clean frame.
        rdy_a = 1'b0;
        send(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, -1, 99, 0);
        chk("rst_pre_valid", 32'(va), 32'd1);
        send(0, 9'h081, 8, 0, 1'b0, 2'b11, 1, -1, 5, 0);
        rx_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_pre_busy", 32'(bsa), 32'd1);
        rst = 1'b1;
        rx_a = 1'b1;
        #1;
        chk("rst_outputs", 32'({va, da, pa, fa, ova, bsa}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy_a = 1'b1;
        repeat (20) @(posedge clk);
        got_q.delete();
        send(0, 9'h081, 8, 0, 1'b0, 2'b11, 1, -1, 99, 1);
        check_frame("post_rst_81");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
# uart_rx_ovs

Parametrised, oversampling UART receiver that replaces the fixed 8-bit receiver in the serial path. It supports configurable data width, parity and stop bits, and uses majority-vote mid-bit sampling with start-bit glitch rejection. Each received frame is delivered on a valid/ready interface with per-frame parity and framing flags and an overrun indication. The block sits between the asynchronous `rx` pin and the byte-consuming logic (FIFO or register file).

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per bit period; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9; sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to clk, idle high.
- `rx_data`  out  DATA_BITS  received data, LSB = first data bit.
- `rx_valid`  out  1  rx_data and flags valid; held until accepted.
- `rx_ready`  in  1  consumer accepts when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch for the presented frame; 0 when PARITY=0.
- `frame_err`  out  1  any stop bit sampled 0 for the presented frame.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input sync: 2-FF synchronizer on `rx`, both flops reset to 1. A falling-edge detector on the synced line compares against a registered previous value, also reset to 1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on a synced 1->0 edge.
  - START -> DATA if the vote = 0; START -> IDLE if the vote = 1 (glitch: no output, no flags).
  - DATA -> PAR after DATA_BITS bits when PARITY≠0, else DATA -> STOP.
  - PAR -> STOP.
  - STOP -> IDLE at the decision point of the last stop bit. The FSM does not wait out the rest of the stop bit.
- Bit timing:
  - `cnt` runs 0..CLKS_PER_BIT-1 within each bit and wraps to 0 as the next bit starts.
  - `cnt` = 0 on the first START cycle.
  - With H = CLKS_PER_BIT/2 (integer division), samples are taken at cnt = H-1, H and H+1.
  - The bit value is the majority of the 3 samples, decided at cnt = H+1.
- Data is shifted in LSB first.
- Parity:
  - Odd: the XOR of the data bits and the parity bit must be 1.
  - Even: that XOR must be 0.
- Frame completion at the STOP decision:
  - If `rx_valid`=0, or `rx_ready`=1 in that same cycle: load `rx_data`, `parity_err` and `frame_err`, and `rx_valid`=1 on the next cycle.
  - Otherwise: drop the new frame, keep the old data and flags, and pulse `overrun` for 1 cycle.
- Frames with errors are still delivered, with their flags set.
- Acceptance: when `rx_valid && rx_ready` with no simultaneous completion, clear `rx_valid` on the next cycle. Flags are don't-care while `rx_valid`=0.
- Break (line held low): the frame completes with data = 0 and `frame_err`=1. No further frame starts until a new 1->0 edge.
- Reset, including mid-frame: abort the frame and return to IDLE. All outputs reset to 0, and `cnt` and the shift register are cleared.

## Timing
- From the clk edge that first samples `rx` low to the first START cycle: 3 cycles (2 sync + 1 edge register).
- First START cycle to `rx_valid` rise: NB·CLKS_PER_BIT + H + 2 cycles, where NB = 1 + DATA_BITS + (PARITY≠0) + (STOP_BITS-1).
  - 8N1 at CLKS_PER_BIT=16: 9·16+10 = 154.
  - Pin-to-valid total for 8N1 at 16: 157 cycles.
- Back-to-back frames: the next start edge is accepted from the cycle after STOP -> IDLE. Mid-bit STOP exit tolerates a sender running up to about 4% faster.
- `overrun` is asserted in the cycle after the dropped frame's STOP decision.

## Test plan
- Baseline, 8N1, CLKS_PER_BIT=16: send 0xA5 with `rx_ready`=1 -> `rx_valid` high for 1 cycle, 157 cycles after the pin falls, with `rx_data`=0xA5 and both flags 0.
- Backpressure and overrun: `rx_ready`=0, send 0x3C then 0xC3 -> `rx_data` stays 0x3C, `overrun` pulses once, `rx_valid` stays high. Raise `rx_ready` -> `rx_valid` falls on the next cycle.
- Parity, DATA_BITS=7, PARITY=2:
  - Send 0x55 with parity 0 -> `parity_err`=0.
  - Same frame with parity 1 -> `parity_err`=1, `rx_data`=0x55.
- Glitch and sampling:
  - A 3-cycle low pulse on an idle line -> no `rx_valid` and `busy` returns to 0.
  - A 1-cycle inverted spike at mid-bit of data bit 2 of 0x00 -> `rx_data`=0x00 (majority vote).
- Framing and break, STOP_BITS=2:
  - Second stop bit low -> `frame_err`=1.
  - Line held low for 40 bit times -> exactly one frame, 0x00 with `frame_err`=1, and no more until the line goes high then low again.
- Reset mid-frame: assert `rst` during data bit 4 -> all outputs 0 immediately. After release, a clean 0x81 frame is received correctly.
